// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared 8x8 data memory.
// Optional bus lock is compiled in with `define DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              b_req,
  input  logic              a_we,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              a_lock,
  input  logic              b_lock,
  output logic              a_ack,
  output logic              b_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              busy,
  output logic              mem_enW,
  output logic [ADDR_W-1:0] mem_addrR,
  output logic [ADDR_W-1:0] mem_addrW,
  output logic [DATA_W-1:0] mem_dataW,
  input  logic [DATA_W-1:0] mem_readD
);

  typedef enum logic [1:0] {StIdle, StServe, StDone} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;    // 0 = A wins a tie, 1 = B wins a tie
  logic              owner_q, owner_d;  // 0 = A, 1 = B
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic grant_valid;
  logic grant_b;

`ifdef DMEM_ARB_LOCK_EN
  logic lock_q, lock_d;
  logic lock_owner_q, lock_owner_d;
  logic lock_release;
  logic owner_lock;
`else
  logic unused_lock;
  assign unused_lock = a_lock ^ b_lock;
`endif

  // Winner selection for the IDLE cycle.
  always_comb begin
    grant_valid = a_req | b_req;
    grant_b     = b_req & (~a_req | prio_q);
`ifdef DMEM_ARB_LOCK_EN
    lock_release = lock_q & ~(lock_owner_q ? b_lock : a_lock);
    owner_lock   = owner_q ? b_lock : a_lock;
    // A held lock restricts the grant to its owner; the other port just waits.
    if (lock_q && !lock_release) begin
      grant_b     = lock_owner_q;
      grant_valid = lock_owner_q ? b_req : a_req;
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    a_rdata_d   = a_rdata_q;
    b_rdata_d   = b_rdata_q;
`ifdef DMEM_ARB_LOCK_EN
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
`endif
    case (state_q)
      StIdle: begin
`ifdef DMEM_ARB_LOCK_EN
        if (lock_release) begin
          lock_d = 1'b0;
        end
`endif
        if (grant_valid) begin
          owner_d     = grant_b;
          cmd_we_d    = grant_b ? b_we    : a_we;
          cmd_addr_d  = grant_b ? b_addr  : a_addr;
          cmd_wdata_d = grant_b ? b_wdata : a_wdata;
          state_d     = StServe;
        end
      end
      StServe: begin
        // Memory writes on the falling edge, so a write reads back its new word here.
        if (owner_q) begin
          b_rdata_d = mem_readD;
        end else begin
          a_rdata_d = mem_readD;
        end
        state_d = StDone;
      end
      StDone: begin
`ifdef DMEM_ARB_LOCK_EN
        if (owner_lock) begin
          lock_d       = 1'b1;
          lock_owner_d = owner_q;
        end else begin
          prio_d = ~owner_q;
        end
`else
        prio_d = ~owner_q;
`endif
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lock_q       <= 1'b0;
      lock_owner_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      a_rdata_q   <= a_rdata_d;
      b_rdata_q   <= b_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
`endif
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    mem_enW   = 1'b0;
    mem_addrR = '0;
    mem_addrW = '0;
    mem_dataW = '0;
    if (state_q == StServe) begin
      // Reset in the memory cycle must not let the write land.
      mem_enW   = cmd_we_q & ~rst;
      mem_addrR = cmd_addr_q;
      mem_addrW = cmd_addr_q;
      mem_dataW = cmd_wdata_q;
    end
    a_ack = (state_q == StDone) & ~owner_q;
    b_ack = (state_q == StDone) & owner_q;
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter and sequencer for the 8×8 data memory. It lets the CPU datapath (port A) and a secondary master such as a loader or debug port (port B) share the memory's single write/read port pair. Each access goes through a registered command stage, one memory cycle, and a one-cycle acknowledge that returns the read data. The block sits between the masters and the memory. It drives the memory's write enable, read/write addresses and write data, and samples its combinational read data.

## Interface
Parameters:
- ADDR_W, 3: memory address width (8 words).
- DATA_W, 8: memory word width.

Ports:
- clk  in  1  system clock. All block state updates on the rising edge. The memory writes on the falling edge.
- rst  in  1  reset, synchronous and active-high.
- a_req, b_req  in  1  access request. Held high until the matching ack.
- a_we, b_we  in  1  1 = write, 0 = read. Held stable while req is high.
- a_addr, b_addr  in  ADDR_W  word address. Held stable while req is high.
- a_wdata, b_wdata  in  DATA_W  write data. Held stable while req is high.
- a_lock, b_lock  in  1  bus-lock request. Used only with DMEM_ARB_LOCK_EN; otherwise ignored.
- a_ack, b_ack  out  1  one-cycle completion pulse.
- a_rdata, b_rdata  out  DATA_W  read data, valid while the matching ack is high; holds its value afterwards.
- busy  out  1  high in SERVE and DONE.
- mem_enW  out  1  memory write enable.
- mem_addrR, mem_addrW  out  ADDR_W  memory read and write addresses.
- mem_dataW  out  DATA_W  memory write data.
- mem_readD  in  DATA_W  memory combinational read data.

## Operation
- FSM states: IDLE, SERVE, DONE. Reset state is IDLE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise pick the winner. If only one req is high, that port wins. If both are high, the port named by the priority pointer `prio` wins (0 = A, 1 = B).
  - Latch the winner's we, addr and wdata into the command registers and record the owner. Go to SERVE.
- SERVE:
  - mem_addrR = mem_addrW = latched addr.
  - mem_dataW = latched wdata.
  - mem_enW = latched we & ~rst.
  - Go to DONE.
  - At the rising edge that leaves SERVE, capture mem_readD into the owner's rdata register. For a write this captures the newly written word, because the memory writes on the mid-cycle falling edge.
- DONE:
  - The owner's ack is high for exactly this cycle. Requests are not sampled.
  - `prio` becomes the non-owner. Go to IDLE.
- Outside SERVE: mem_enW = 0, mem_addrR = mem_addrW = 0, mem_dataW = 0.
- The requester must drop req, or present a new command, on the edge after it sees ack. A req held high is treated as a new access in the next IDLE.
- A req that rises while the arbiter is in SERVE or DONE waits for the next IDLE. No request is lost.
- Deasserting req before ack is a protocol violation. The latched command still completes and is acked.

## Timing
- Reset values:
  - state = IDLE, prio = 0 (A), busy = 0.
  - a_ack = b_ack = 0.
  - a_rdata = b_rdata = 0.
  - all mem_* outputs = 0.
- Latency: req sampled high in IDLE at edge N. SERVE runs in cycle N+1. ack is high in cycle N+2.
- Throughput: one access per 3 cycles. Two back-to-back contending masters alternate A, B, A, B.
- rst high during SERVE:
  - mem_enW is forced to 0 in that cycle, so the memory is not written.
  - At the edge, the FSM goes to IDLE and no ack is issued.
- rst high during DONE: ack is suppressed from that edge on and rdata clears to 0.
- Simultaneous req rising on A and B in IDLE: resolved by `prio` only. There is no combinational path from req to ack.

## Configuration
- DMEM_ARB_LOCK_EN defined:
  - If the owner's lock input is high during DONE, `prio` is not rotated and the lock becomes held for that owner.
  - While the lock is held, IDLE grants only the lock owner. The other port's req waits.
  - The lock is released in the first IDLE cycle in which the owner's lock input is low. Normal arbitration resumes in that same cycle.
  - Reset clears the lock.
- DMEM_ARB_LOCK_EN undefined: the lock inputs are ignored, there is no lock register, and pure round-robin applies.

## Test plan
- Reset then single write: A writes addr 3 with 0x5A (a_req=1, a_we=1).
  - Expected: mem_enW=1 only in cycle 2.
  - Expected: a_ack in cycle 3, a_rdata=0x5A.
  - Expected: memory word 3 = 0x5A.
- Read back: B reads addr 3 → b_ack after 3 cycles, b_rdata=0x5A, mem_enW stays 0.
- Contention from reset: A and B request in the same cycle. A writes 0x11 to addr 1; B reads addr 1.
  - Expected: A is served first (prio=0) and B second.
  - Expected: b_rdata=0x11.
  - Expected: repeating both requests continuously gives an ack order of A, B, A, B.
- Reset mid-access: assert rst during the SERVE cycle of an A write of 0xFF to addr 7.
  - Expected: memory word 7 is unchanged and no ack is issued.
  - Expected: state is IDLE and all outputs are 0.
- Held req: A keeps req high for 9 cycles with B idle → three acks, in cycles 3, 6 and 9.
- With DMEM_ARB_LOCK_EN: A holds a_lock=1 across a read then a write of addr 2, while B requests continuously.
  - Expected: B gets no ack until A drops a_lock.
  - Expected: B is then served in the next access slot.
